// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle for the fetch/data to single-port memory arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters/memory side.
interface riscv_mem_arbiter_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned BE_W = 4;

  logic            i_if_req;
  logic [XLEN-1:0] i_if_addr;
  logic            o_if_gnt;
  logic            o_if_rvalid;
  logic [XLEN-1:0] o_if_rdata;

  logic            i_dm_req;
  logic            i_dm_we;
  logic [BE_W-1:0] i_dm_be;
  logic [XLEN-1:0] i_dm_addr;
  logic [XLEN-1:0] i_dm_wdata;
  logic            o_dm_gnt;
  logic            o_dm_rvalid;
  logic [XLEN-1:0] o_dm_rdata;

  logic            o_mem_req;
  logic            o_mem_we;
  logic [BE_W-1:0] o_mem_be;
  logic [XLEN-1:0] o_mem_addr;
  logic [XLEN-1:0] o_mem_wdata;
  logic            i_mem_ack;
  logic [XLEN-1:0] i_mem_rdata;

  logic            o_busy;

  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_gnt, o_if_rvalid, o_if_rdata,
    input  i_dm_req, i_dm_we, i_dm_be, i_dm_addr, i_dm_wdata,
    output o_dm_gnt, o_dm_rvalid, o_dm_rdata,
    output o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
    input  i_mem_ack, i_mem_rdata,
    output o_busy
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_gnt, o_if_rvalid, o_if_rdata,
    output i_dm_req, i_dm_we, i_dm_be, i_dm_addr, i_dm_wdata,
    input  o_dm_gnt, o_dm_rvalid, o_dm_rdata,
    input  o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
    output i_mem_ack, i_mem_rdata,
    input  o_busy
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory, one
// transaction at a time, with data priority bounded by a fetch-starvation limit.
module riscv_mem_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  riscv_mem_arbiter_if.slave  bus
);

  localparam int unsigned BE_W  = 4;
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e          state_q,      state_d;
  logic            resp_fetch_q, resp_fetch_d;
  logic            we_q,         we_d;
  logic [BE_W-1:0] be_q,         be_d;
  logic [XLEN-1:0] addr_q,       addr_d;
  logic [XLEN-1:0] wdata_q,      wdata_d;
  logic [XLEN-1:0] if_rdata_q,   if_rdata_d;
  logic [XLEN-1:0] dm_rdata_q,   dm_rdata_d;
  logic [CNT_W-1:0] starve_q,    starve_d;

  logic if_gnt_c;
  logic dm_gnt_c;
  logic starved_c;

  // State and captured-field registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      resp_fetch_q <= 1'b0;
      we_q         <= 1'b0;
      be_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      starve_q     <= '0;
    end else begin
      state_q      <= state_d;
      resp_fetch_q <= resp_fetch_d;
      we_q         <= we_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      starve_q     <= starve_d;
    end
  end

  // Arbitration, next-state and field capture
  always_comb begin
    state_d      = state_q;
    resp_fetch_d = resp_fetch_q;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    starve_d     = starve_q;
    if_gnt_c     = 1'b0;
    dm_gnt_c     = 1'b0;
    starved_c    = (starve_q == CNT_W'(STARVE_LIMIT));

    case (state_q)
      IDLE: begin
        if (!i_rst) begin
          if (bus.i_dm_req && !(bus.i_if_req && starved_c)) begin
            dm_gnt_c = 1'b1;
          end else if (bus.i_if_req) begin
            if_gnt_c = 1'b1;
          end
        end
        if (dm_gnt_c) begin
          state_d      = WAIT_D;
          resp_fetch_d = 1'b0;
          we_d         = bus.i_dm_we;
          be_d         = bus.i_dm_be;
          addr_d       = bus.i_dm_addr;
          wdata_d      = bus.i_dm_wdata;
        end else if (if_gnt_c) begin
          state_d      = WAIT_I;
          resp_fetch_d = 1'b1;
          we_d         = 1'b0;
          be_d         = {BE_W{1'b1}};
          addr_d       = bus.i_if_addr;
          wdata_d      = '0;
        end
      end
      WAIT_I: begin
        if (bus.i_mem_ack) begin
          state_d    = RESP;
          if_rdata_d = bus.i_mem_rdata;
        end
      end
      WAIT_D: begin
        if (bus.i_mem_ack) begin
          state_d    = RESP;
          dm_rdata_d = we_q ? '0 : bus.i_mem_rdata;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Count data wins while fetch is kept waiting; any fetch grant or idle fetch clears it
    if (!bus.i_if_req || if_gnt_c) begin
      starve_d = '0;
    end else if (dm_gnt_c && !starved_c) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  assign bus.o_if_gnt    = if_gnt_c;
  assign bus.o_dm_gnt    = dm_gnt_c;
  assign bus.o_mem_req   = (state_q == WAIT_I) || (state_q == WAIT_D);
  assign bus.o_mem_we    = we_q;
  assign bus.o_mem_be    = be_q;
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_mem_wdata = wdata_q;
  assign bus.o_if_rvalid = (state_q == RESP) &&  resp_fetch_q;
  assign bus.o_dm_rvalid = (state_q == RESP) && !resp_fetch_q;
  assign bus.o_if_rdata  = if_rdata_q;
  assign bus.o_dm_rdata  = dm_rdata_q;
  assign bus.o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench for riscv_mem_arbiter: stimulus pushes expected grants, memory
// fields and responses; negedge monitors pop and compare as the DUT presents them.
module tb_riscv_mem_arbiter;
  localparam int unsigned XLEN = 32;

  typedef struct {
    logic        fetch;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } memx_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  riscv_mem_arbiter_if #(.XLEN(XLEN)) bus ();

  riscv_mem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  rsp_t  rsp_q[$];
  memx_t mem_q[$];
  logic  gnt_q[$];
  int    gnt_cyc[$];

  bit mem_auto    = 1'b1;
  int ack_delay   = 0;
  int ack_cyc     = 0;
  int manual_n    = 0;
  int manual_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_content(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory model: acks after ack_delay stall cycles, or on a manual spurious pulse
  initial begin
    int stall;
    stall = 0;
    bus.i_mem_ack   = 1'b0;
    bus.i_mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.i_mem_ack) begin
        bus.i_mem_ack = 1'b0;
      end else if (manual_n != manual_done) begin
        manual_done     = manual_n;
        bus.i_mem_ack   = 1'b1;
        bus.i_mem_rdata = 32'hBAD0_BAD0;
        ack_cyc         = cyc;
      end else if (mem_auto && bus.o_mem_req) begin
        if (stall >= ack_delay) begin
          bus.i_mem_ack   = 1'b1;
          bus.i_mem_rdata = mem_content(bus.o_mem_addr);
          ack_cyc         = cyc;
          stall           = 0;
        end else begin
          stall++;
        end
      end
    end
  end

  // Grant monitor
  always @(negedge clk) begin
    if (bus.o_if_gnt || bus.o_dm_gnt) begin
      chk("gnt_onehot", 32'(bus.o_if_gnt & bus.o_dm_gnt), 32'd0);
      if (gnt_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL gnt_unexpected: got if=%0b dm=%0b, required no grant", bus.o_if_gnt, bus.o_dm_gnt);
      end else begin
        chk("gnt_port", 32'(bus.o_if_gnt), 32'(gnt_q.pop_front()));
      end
      gnt_cyc.push_back(cyc);
    end
  end

  // Memory-side monitor: first request cycle matches expectation, later cycles stay stable
  logic  prev_req = 1'b0;
  memx_t held;
  always @(negedge clk) begin
    if (bus.o_mem_req) begin
      if (!prev_req) begin
        if (mem_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL mem_unexpected: got addr 0x%0h, required no request", bus.o_mem_addr);
        end else begin
          memx_t e;
          e = mem_q.pop_front();
          chk("mem_we",   32'(bus.o_mem_we), 32'(e.we));
          chk("mem_be",   32'(bus.o_mem_be), 32'(e.be));
          chk("mem_addr", bus.o_mem_addr, e.addr);
          if (e.we) chk("mem_wdata", bus.o_mem_wdata, e.wdata);
        end
        held.we    <= bus.o_mem_we;
        held.be    <= bus.o_mem_be;
        held.addr  <= bus.o_mem_addr;
        held.wdata <= bus.o_mem_wdata;
      end else begin
        chk("mem_stable", {bus.o_mem_addr[26:0], bus.o_mem_be, bus.o_mem_we},
                          {held.addr[26:0], held.be, held.we});
        chk("mem_wdata_stable", bus.o_mem_wdata, held.wdata);
      end
    end
    prev_req <= bus.o_mem_req;
  end

  // Response monitor
  always @(negedge clk) begin
    if (bus.o_if_rvalid || bus.o_dm_rvalid) begin
      chk("rvalid_onehot", 32'(bus.o_if_rvalid & bus.o_dm_rvalid), 32'd0);
      if (rsp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL rvalid_unexpected: got if=%0b dm=%0b, required none", bus.o_if_rvalid, bus.o_dm_rvalid);
      end else begin
        rsp_t r;
        r = rsp_q.pop_front();
        chk("rsp_port", 32'(bus.o_if_rvalid), 32'(r.fetch));
        chk("rsp_data", r.fetch ? bus.o_if_rdata : bus.o_dm_rdata, r.data);
        chk("rsp_latency", 32'(cyc), 32'(ack_cyc + 1));
      end
    end
  end

  task automatic expect_txn(input bit fetch, input bit we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input bit has_rsp, input logic [31:0] rdata);
    memx_t m;
    rsp_t  r;
    m.we = fetch ? 1'b0 : we;
    m.be = fetch ? 4'hF : be;
    m.addr = addr;
    m.wdata = wdata;
    gnt_q.push_back(fetch);
    mem_q.push_back(m);
    if (has_rsp) begin
      r.fetch = fetch;
      r.data  = rdata;
      rsp_q.push_back(r);
    end
  endtask

  // Raise one request, hold it until granted, then drop it and scramble its inputs
  task automatic do_req(input bit fetch, input bit we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    if (fetch) begin
      bus.i_if_req = 1'b1; bus.i_if_addr = addr;
    end else begin
      bus.i_dm_req = 1'b1; bus.i_dm_we = we; bus.i_dm_be = be;
      bus.i_dm_addr = addr; bus.i_dm_wdata = wdata;
    end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = fetch ? bus.o_if_gnt : bus.o_dm_gnt;
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL gnt_timeout: got no grant within 50 cycles, required a grant");
    end
    @(posedge clk); #1;
    bus.i_if_req = 1'b0; bus.i_dm_req = 1'b0;
    bus.i_if_addr = 32'hFFFF_FFF0; bus.i_dm_addr = 32'hFFFF_FFF4;
    bus.i_dm_we = ~bus.i_dm_we; bus.i_dm_be = ~bus.i_dm_be; bus.i_dm_wdata = 32'h5555_AAAA;
  endtask

  // Hold the chosen requests continuously until n grants have been issued
  task automatic hold_reqs(input bit if_on, input bit dm_on, input int n);
    int cnt;
    cnt = 0;
    @(posedge clk); #1;
    bus.i_if_req = if_on; bus.i_dm_req = dm_on;
    for (int i = 0; i < 400 && cnt < n; i++) begin
      @(negedge clk);
      if (bus.o_if_gnt || bus.o_dm_gnt) cnt++;
    end
    if (cnt < n) begin
      n_tests++; n_fail++;
      $display("FAIL hold_timeout: got %0d grants, required %0d", cnt, n);
    end
    @(posedge clk); #1;
    bus.i_if_req = 1'b0; bus.i_dm_req = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = (rsp_q.size() == 0) && (mem_q.size() == 0) && (gnt_q.size() == 0) && !bus.o_busy;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: got rsp_q=%0d mem_q=%0d gnt_q=%0d busy=%0b, required empty/idle",
               rsp_q.size(), mem_q.size(), gnt_q.size(), bus.o_busy);
    end
  endtask

  initial begin
    int base;
    rst = 1'b1;
    bus.i_if_req = 1'b1; bus.i_if_addr = 32'h0000_0040;
    bus.i_dm_req = 1'b1; bus.i_dm_we = 1'b0; bus.i_dm_be = 4'hF;
    bus.i_dm_addr = 32'h0000_0080; bus.i_dm_wdata = '0;

    // Reset state, grants suppressed while reset is high
    repeat (2) @(negedge clk);
    chk("rst_if_gnt",   32'(bus.o_if_gnt), 32'd0);
    chk("rst_dm_gnt",   32'(bus.o_dm_gnt), 32'd0);
    chk("rst_busy",     32'(bus.o_busy), 32'd0);
    chk("rst_mem_req",  32'(bus.o_mem_req), 32'd0);
    chk("rst_rvalid",   32'({bus.o_if_rvalid, bus.o_dm_rvalid}), 32'd0);
    chk("rst_mem_addr", bus.o_mem_addr, 32'd0);
    chk("rst_if_rdata", bus.o_if_rdata, 32'd0);
    @(posedge clk); #1;
    bus.i_if_req = 1'b0; bus.i_dm_req = 1'b0;
    rst = 1'b0;

    // Single fetch, ack in the first WAIT cycle
    ack_delay = 0;
    expect_txn(1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'd0, 1'b1, 32'h0050_0093);
    do_req(1'b1, 1'b0, 4'h0, 32'h0000_0100, 32'd0);
    drain();

    // Data write with 5 stall cycles; write completion returns 0
    ack_delay = 5;
    expect_txn(1'b0, 1'b1, 4'b0011, 32'h0000_0204, 32'hDEAD_BEEF, 1'b1, 32'd0);
    do_req(1'b0, 1'b1, 4'b0011, 32'h0000_0204, 32'hDEAD_BEEF);
    drain();
    chk("if_rdata_hold", bus.o_if_rdata, 32'h0050_0093);

    // Data read with 2 stall cycles
    ack_delay = 2;
    expect_txn(1'b0, 1'b0, 4'hC, 32'h0000_0208, 32'd0, 1'b1, 32'hA5A5_0208);
    do_req(1'b0, 1'b0, 4'hC, 32'h0000_0208, 32'd0);
    drain();

    // Both held: D,D,D,D,I,D,D,D,D,I
    ack_delay = 0;
    bus.i_if_addr = 32'h0000_0400;
    bus.i_dm_we = 1'b0; bus.i_dm_be = 4'hF; bus.i_dm_addr = 32'h0000_0300;
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9)
        expect_txn(1'b1, 1'b0, 4'hF, 32'h0000_0400, 32'd0, 1'b1, 32'hA5A5_0400);
      else
        expect_txn(1'b0, 1'b0, 4'hF, 32'h0000_0300, 32'd0, 1'b1, 32'hA5A5_0300);
    end
    hold_reqs(1'b1, 1'b1, 10);
    drain();

    // Reset mid-transaction in WAIT_D: abandoned, later ack ignored
    mem_auto = 1'b0;
    expect_txn(1'b0, 1'b0, 4'h1, 32'h0000_0210, 32'd0, 1'b0, 32'd0);
    do_req(1'b0, 1'b0, 4'h1, 32'h0000_0210, 32'd0);
    @(negedge clk);
    chk("waitd_busy",    32'(bus.o_busy), 32'd1);
    chk("waitd_mem_req", 32'(bus.o_mem_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("async_mem_req", 32'(bus.o_mem_req), 32'd0);
    chk("async_busy",    32'(bus.o_busy), 32'd0);
    chk("async_addr",    bus.o_mem_addr, 32'd0);
    chk("async_if_rdata", bus.o_if_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    manual_n++;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", 32'(bus.o_busy), 32'd0);
    mem_auto = 1'b1;
    expect_txn(1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'd0, 1'b1, 32'h0050_0093);
    do_req(1'b1, 1'b0, 4'h0, 32'h0000_0100, 32'd0);
    drain();

    // Spurious ack in IDLE with no requests
    mem_auto = 1'b0;
    manual_n++;
    repeat (3) @(negedge clk);
    chk("spurious_busy",    32'(bus.o_busy), 32'd0);
    chk("spurious_mem_req", 32'(bus.o_mem_req), 32'd0);
    mem_auto = 1'b1;

    // Back-to-back fetches with immediate ack: grants 3 cycles apart
    ack_delay = 0;
    bus.i_if_addr = 32'h0000_0500;
    for (int k = 0; k < 3; k++)
      expect_txn(1'b1, 1'b0, 4'hF, 32'h0000_0500, 32'd0, 1'b1, 32'hA5A5_0500);
    base = gnt_cyc.size();
    hold_reqs(1'b1, 1'b0, 3);
    drain();
    if (gnt_cyc.size() < base + 3) begin
      n_tests++; n_fail++;
      $display("FAIL b2b_count: got %0d grants, required 3", gnt_cyc.size() - base);
    end else begin
      chk("b2b_spacing_1", 32'(gnt_cyc[base + 1] - gnt_cyc[base]), 32'd3);
      chk("b2b_spacing_2", 32'(gnt_cyc[base + 2] - gnt_cyc[base + 1]), 32'd3);
    end

    chk("end_rsp_q", 32'(rsp_q.size()), 32'd0);
    chk("end_mem_q", 32'(mem_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 time units, required finish");
    $fatal(1, "watchdog");
  end

endmodule
